// File: rtl/piso_shift_ctrl_if.sv
// piso_shift_ctrl_if: word-in / bit-out handshake bundle for piso_shift_ctrl
// Ports: in_valid/in_ready/Data_in (parallel input handshake),
//        out_valid/out_ready/sout/out_last (serial output handshake), busy (word in flight).
// slave is the shifter side, master is the producer/consumer side.
interface piso_shift_ctrl_if #(parameter int WIDTH = 4) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Data_in;
    logic             out_valid;
    logic             out_ready;
    logic             sout;
    logic             out_last;
    logic             busy;
    modport slave (
        input  in_valid, Data_in, out_ready,
        output in_ready, out_valid, sout, out_last, busy
    );
    modport master (
        output in_valid, Data_in, out_ready,
        input  in_ready, out_valid, sout, out_last, busy
    );
endinterface

// File: rtl/piso_shift_ctrl.sv
// piso_shift_ctrl: parallel-load / serial-shift sequencer with valid/ready on both sides
// Ports: clk, rst (async, active-low), bus (piso_shift_ctrl_if.slave).
// Parameters: WIDTH (>= 2) word width, MSB_FIRST selects which end is shifted out first.
module piso_shift_ctrl #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input logic               clk,
    input logic               rst,
    piso_shift_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             load;
    logic             beat;
    assign bus.out_valid = state == SHIFT;
    assign bus.busy      = state == SHIFT;
    // cnt is 0 in IDLE and WIDTH-1 >= 1, so out_last cannot fire outside SHIFT
    assign bus.out_last  = cnt == LAST;
    // sreg is cleared whenever the block goes idle, so sout reads 0 there
    assign bus.sout      = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    // out_ready feeds in_ready combinationally so the next word loads on the last beat
    assign bus.in_ready  = rst & (state == IDLE | (bus.out_last & bus.out_ready));
    assign load = bus.in_valid & bus.in_ready;
    assign beat = bus.out_valid & bus.out_ready;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else if (load) begin
            state <= SHIFT;
            sreg  <= bus.Data_in;
            cnt   <= '0;
        end else if (beat && bus.out_last) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else if (beat) begin
            sreg  <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
            cnt   <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_piso_shift_ctrl.sv
// tb_piso_shift_ctrl: directed + random check of both bit orders against a word/remaining-bits model
module tb_piso_shift_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       iv = 1'b0;
    logic       ordy = 1'b0;
    logic [3:0] din = 4'd0;
    int         vectors = 0;
    int         miscompares = 0;
    int         rem = 0;
    logic [3:0] w = 4'd0;
    always #5 clk = ~clk;
    piso_shift_ctrl_if #(.WIDTH(4)) b0 ();
    piso_shift_ctrl_if #(.WIDTH(4)) b1 ();
    assign b0.in_valid  = iv;
    assign b0.Data_in   = din;
    assign b0.out_ready = ordy;
    assign b1.in_valid  = iv;
    assign b1.Data_in   = din;
    assign b1.out_ready = ordy;
    piso_shift_ctrl #(.WIDTH(4), .MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    piso_shift_ctrl #(.WIDTH(4), .MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    function automatic logic exp_ready();
        return rst && (rem == 0 || (rem == 1 && ordy));
    endfunction
    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask
    task automatic verify();
        logic v;
        logic s0;
        logic s1;
        v  = rem > 0;
        s0 = v ? w[4 - rem] : 1'b0;
        s1 = v ? w[rem - 1] : 1'b0;
        chk("lsb.in_ready", b0.in_ready, exp_ready());
        chk("lsb.out_valid", b0.out_valid, v);
        chk("lsb.busy", b0.busy, v);
        chk("lsb.out_last", b0.out_last, rem == 1);
        chk("lsb.sout", b0.sout, s0);
        chk("msb.in_ready", b1.in_ready, exp_ready());
        chk("msb.out_valid", b1.out_valid, v);
        chk("msb.busy", b1.busy, v);
        chk("msb.out_last", b1.out_last, rem == 1);
        chk("msb.sout", b1.sout, s1);
    endtask
    task automatic cyc(input logic r, input logic v, input logic [3:0] d, input logic o);
        @(negedge clk);
        rst = r;
        iv = v;
        din = d;
        ordy = o;
        if (!r) rem = 0;
        #1 verify();
        @(posedge clk);
        if (r) begin
            if (v && exp_ready()) begin
                w = d;
                rem = 4;
            end else if (rem > 0 && o) begin
                rem--;
            end
        end
    endtask
    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 4'd0, 1'b1);
    endtask
    initial begin
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'd0, 1'b1);
        drain(2);
        cyc(1'b1, 1'b1, 4'b1011, 1'b1);
        drain(5);
        cyc(1'b1, 1'b1, 4'b0110, 1'b1);
        drain(2);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 4'd0, 1'b0);
        drain(3);
        cyc(1'b1, 1'b1, 4'b1100, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 4'b0011, 1'b1);
        drain(5);
        cyc(1'b1, 1'b1, 4'b1000, 1'b1);
        drain(5);
        cyc(1'b1, 1'b1, 4'b1111, 1'b1);
        drain(2);
        cyc(1'b0, 1'b0, 4'd0, 1'b1);
        cyc(1'b0, 1'b1, 4'b1111, 1'b1);
        cyc(1'b1, 1'b1, 4'b0001, 1'b1);
        drain(5);
        for (int i = 0; i < 500; i++)
            cyc(($urandom % 64) != 0, 1'($urandom % 2), 4'($urandom), ($urandom % 4) != 0);
        drain(8);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
